soc_eq_solver_hps_done: RTL and testbench
=========================================

# soc_eq_solver_hps_done

Avalon-MM slave input port carrying solver status from the FPGA fabric back to the HPS: the return path for the HPS-driven `ready` output port. It synchronizes `WIDTH` status lines (bit 0 = solver done), latches their rising edges in a write-1-to-clear capture register, and raises a maskable interrupt so HPS software can sleep until the solver finishes. It sits on the lightweight HPS-to-FPGA bridge next to the other solver PIOs.

## Interface
- `WIDTH`, 1: number of status input lines, legal range 1..32.

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  word address: 0 = data, 1 = reserved, 2 = irqmask, 3 = edgecapture.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; read when `chipselect` && `write_n`.
- `writedata`  in  32  write data.
- `in_port`  in  `WIDTH`  asynchronous status lines from the solver.
- `readdata`  out  32  registered read data, zero-extended above `WIDTH`.
- `irq`  out  1  level interrupt to the HPS.

## Operation
- Reset values: `sync1`, `sync2` and `prev` = 0; `edgecapture` = 0; `irqmask` = 0; `readdata` = 0; `irq` = 0.
- Synchronizer chain:
  - `sync1` <= `in_port`.
  - `sync2` <= `sync1`.
  - `prev` <= `sync2`.
- Edge detect: `edge` = `sync2` & ~`prev`, evaluated per bit.
- Capture, per bit i: `edgecapture[i]` <= `edge[i]` | (`edgecapture[i]` & ~`clr[i]`).
  - `clr` = `writedata[WIDTH-1:0]` when `chipselect` && ~`write_n` && `address` == 3, else 0.
  - If set and clear hit the same bit in the same cycle, set wins.
- Mask register: write at `address` 2 loads `irqmask` <= `writedata[WIDTH-1:0]`.
- Interrupt: `irq` = |(`edgecapture` & `irqmask`). It is combinational from registers, so it has no glitch path from `in_port`.
- Read mux, per address:
  - 0 returns `sync2`.
  - 1 returns 0.
  - 2 returns `irqmask`.
  - 3 returns `edgecapture`.
  - Bits [31:WIDTH] always read 0.
- `readdata` is updated only on a read cycle and holds its value otherwise.
- Writes to `address` 0 and 1 are ignored.
- Reset mid-operation clears all state immediately.
  - An input still high when `reset_n` deasserts produces exactly one capture, 2 cycles after the first clock edge.

## Timing
- Label E0 as the edge that samples a new `in_port` value into `sync1`.
  - `sync2` changes at E1.
  - `edgecapture` sets at E2.
  - `irq` rises after E2 if that bit is masked in.
  - `in_port`-to-`irq` latency is 3 clocks.
- Data-register read latency is 1 cycle: the read issued at edge E returns the `sync2` value as it stood just before E, and `readdata` is valid after E.
- Write-1-to-clear at edge E:
  - `edgecapture` and `irq` drop after E.
  - A clear and a fresh edge at the same E leave the bit set.
- A mask write at edge E takes effect on `irq` after E.
- No wait states; every access completes in the addressed cycle.
- Pulses on `in_port` shorter than 2 clocks may be lost; the solver holds done for at least 2 clocks.

## Configuration
- `SOC_EQ_SOLVER_DONE_IRQ_EN` defined:
  - `irqmask` register and `irq` logic are present, as described above.
- `SOC_EQ_SOLVER_DONE_IRQ_EN` undefined:
  - No `irqmask` flops.
  - `irq` is tied 0.
  - `address` 2 reads 0 and ignores writes.
  - Edge capture, clearing and the data register are unchanged, so software polls `address` 3.

## Test plan
- Reset check: hold `reset_n`=0 with `in_port`=1, then release. `readdata`, `irq` and `irqmask` are 0 during reset; `edgecapture` reads 0x1 after the third post-reset edge.
- Edge latency: with `WIDTH`=1, write `irqmask`=1, then raise `in_port` for 4 cycles. `irq` rises exactly 3 clocks after the sampling edge, and a read of `address` 0 returns 0x00000001.
- Write-1-to-clear: with `edgecapture`=1, write 0x1 to `address` 3. `irq` drops the next cycle and `address` 3 reads 0. Writing 0x0 leaves the bit set.
- Set-vs-clear collision: time a clear write on the same edge that sets `edgecapture`. The bit remains 1 and `irq` stays high.
- Masking, with `WIDTH`=4: set `irqmask`=0x4 and pulse `in_port` bits 0 and 2. `edgecapture` reads 0x5 and `irq`=1. Clear bit 2 only; `irq`=0 and `edgecapture` reads 0x1.
- Macro undefined: repeat the edge-latency scenario. `irq` stays 0, `address` 2 reads 0 after writing 0xF, and `address` 3 still reads 0x1.

Source files
------------

// File: rtl/soc_eq_solver_hps_done.sv
// Solver status PIO on the lightweight HPS bridge: synchronized status lines,
// W1C rising-edge capture, and an optional maskable interrupt (SOC_EQ_SOLVER_DONE_IRQ_EN).
module soc_eq_solver_hps_done #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] mask_val;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             rd_en;
  logic             unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign rd_en        = chipselect && write_n;
  assign edge_det     = sync2 & ~prev;
  assign clr          = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // A fresh edge wins over a same-cycle clear so no completion is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
    end else begin
      edgecapture <= edge_det | (edgecapture & ~clr);
    end
  end

`ifdef SOC_EQ_SOLVER_DONE_IRQ_EN
  logic [WIDTH-1:0] irqmask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (wr_en && address == 2'd2) begin
      irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign mask_val = irqmask;
  assign irq      = |(edgecapture & irqmask);
`else
  assign mask_val = '0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[WIDTH-1:0] = sync2;
      2'd2:    rd_next[WIDTH-1:0] = mask_val;
      2'd3:    rd_next[WIDTH-1:0] = edgecapture;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_soc_eq_solver_hps_done.sv
// Directed self-checking bench for soc_eq_solver_hps_done (WIDTH=4); expectations
// follow SOC_EQ_SOLVER_DONE_IRQ_EN when it is defined for the build.
module tb_soc_eq_solver_hps_done;

  localparam int WIDTH = 4;
`ifdef SOC_EQ_SOLVER_DONE_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int assert_count = 0;
  int fail_count   = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  soc_eq_solver_hps_done #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  // One bus cycle spanning a single rising edge; returns 1 time unit after it.
  task automatic applyStimulus(input logic cs, input logic wn, input logic [1:0] addr,
                               input logic [31:0] data);
    chipselect = cs;
    write_n    = wn;
    address    = addr;
    writedata  = data;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h0);
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, addr, data);
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    applyStimulus(1'b1, 1'b1, addr, 32'h0);
    data = readdata;
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    in_port    = 4'h1;

    // Reset held with the input already high
    idle();
    bus_read(2'd3, rd);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;

    bus_read(2'd2, rd);
    checkOutput("reset_irqmask", rd, 32'h0);
    bus_read(2'd3, rd);
    checkOutput("post_reset_ec_e1", rd, 32'h0);
    bus_read(2'd3, rd);
    checkOutput("post_reset_ec_e2", rd, 32'h0);
    bus_read(2'd3, rd);
    checkOutput("post_reset_ec_e3", rd, 32'h1);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd);
    checkOutput("post_reset_single_capture", rd, 32'h0);
    in_port = 4'h0;
    repeat (4) idle();

    // Edge latency, bit 0
    bus_write(2'd2, 32'h1);
    in_port = 4'h1;
    idle();
    checkOutput("latency_irq_e0", {31'h0, irq}, 32'h0);
    idle();
    checkOutput("latency_irq_e1", {31'h0, irq}, 32'h0);
    idle();
    checkOutput("latency_irq_e2", {31'h0, irq}, {31'h0, IRQ_EN});
    bus_read(2'd0, rd);
    checkOutput("data_read", rd, 32'h1);
    in_port = 4'h0;
    bus_read(2'd3, rd);
    checkOutput("latency_ec", rd, 32'h1);
    idle();
    checkOutput("readdata_hold", readdata, 32'h1);

    // Write-1-to-clear
    bus_write(2'd3, 32'h0);
    bus_read(2'd3, rd);
    checkOutput("w0_keeps_bit", rd, 32'h1);
    checkOutput("w0_keeps_irq", {31'h0, irq}, {31'h0, IRQ_EN});
    bus_write(2'd3, 32'h1);
    checkOutput("w1c_irq_drop", {31'h0, irq}, 32'h0);
    bus_read(2'd3, rd);
    checkOutput("w1c_ec", rd, 32'h0);
    repeat (3) idle();

    // Clear lands on the same edge that sets the bit
    in_port = 4'h1;
    idle();
    idle();
    bus_write(2'd3, 32'h1);
    checkOutput("collision_irq", {31'h0, irq}, {31'h0, IRQ_EN});
    bus_read(2'd3, rd);
    checkOutput("collision_ec", rd, 32'h1);
    in_port = 4'h0;
    repeat (3) idle();
    bus_write(2'd3, 32'hF);

    // Masking across several bits
    bus_write(2'd2, 32'h4);
    in_port = 4'h5;
    repeat (3) idle();
    in_port = 4'h0;
    checkOutput("mask_irq_set", {31'h0, irq}, {31'h0, IRQ_EN});
    bus_read(2'd3, rd);
    checkOutput("mask_ec_5", rd, 32'h5);
    bus_write(2'd3, 32'h4);
    checkOutput("mask_irq_clear", {31'h0, irq}, 32'h0);
    bus_read(2'd3, rd);
    checkOutput("mask_ec_1", rd, 32'h1);

    // Register map: readback, reserved, ignored writes, zero extension
    bus_write(2'd2, 32'hF);
    bus_read(2'd2, rd);
    checkOutput("irqmask_readback", rd, IRQ_EN ? 32'hF : 32'h0);
    checkOutput("irq_full_mask", {31'h0, irq}, {31'h0, IRQ_EN});
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, rd);
    checkOutput("irqmask_zero_ext", rd, IRQ_EN ? 32'hF : 32'h0);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, rd);
    checkOutput("reserved_read", rd, 32'h0);
    bus_write(2'd0, 32'hF);
    bus_read(2'd3, rd);
    checkOutput("addr0_write_ignored", rd, 32'h1);

    // Asynchronous reset mid-operation
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_readdata", readdata, 32'h0);
    checkOutput("midreset_irq", {31'h0, irq}, 32'h0);
    idle();
    reset_n = 1'b1;
    idle();
    bus_read(2'd3, rd);
    checkOutput("midreset_ec", rd, 32'h0);
    bus_read(2'd2, rd);
    checkOutput("midreset_irqmask", rd, 32'h0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
